// File: rtl/leg_pkg.sv
// rtl/leg_pkg.sv - shared LEGv8 control types, opcode patterns and mux encodings
package leg_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_LD, WB_LD, MEM_ST, CBZ_EX, TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_ILL
  } op_class_t;

  // casez patterns over IR[31:21]
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0???;
  localparam logic [10:0] OP_R    = 11'b1??_0101_?000;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_PASSB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // STUR and CBZ read Rt through the second register port
  function automatic logic uses_rt_as_b(input op_class_t c);
    return (c == CLS_STUR) || (c == CLS_CBZ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath/control signal bundle for the multicycle controller
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [10:0]      Op;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             MemtoReg;
  logic             Reg2Loc;
  logic             ALUSrcA;
  logic             PCSrc;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc,
           ALUSrcA, PCSrc, ALUSrcB, ALUOp, instr_done, illegal, instr_count
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc,
           ALUSrcA, PCSrc, ALUSrcB, ALUOp, instr_done, illegal, instr_count
  );
endinterface

// File: rtl/op_class.sv
// rtl/op_class.sv - combinational opcode-to-class decode shared with the main decoder
module op_class
  import leg_pkg::*;
(
  input  logic [10:0] op,
  output op_class_t   cls
);

  always_comb begin
    cls = CLS_ILL;
    casez (op)
      OP_LDUR: cls = CLS_LDUR;
      OP_STUR: cls = CLS_STUR;
      OP_CBZ:  cls = CLS_CBZ;
      OP_R:    cls = CLS_R;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM sequencing one LEGv8 instruction at a time
module multicycle_ctrl
  import leg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t           state, state_nx;
  op_class_t        cls_q, cls_live, cls_cur;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg;
  logic       alu_src_a, pc_src, reg2loc, done;
  logic [1:0] alu_src_b, alu_op;

  op_class u_op_class (
    .op  (bus.Op),
    .cls (cls_live)
  );

  // Op is only meaningful from DECODE on, so DECODE uses the live decode
  assign cls_cur = (state == DECODE) ? cls_live : cls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      cls_q     <= CLS_R;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE)
        cls_q <= cls_live;
      if (state_nx == TRAP)
        illegal_q <= 1'b1;
      if (done)
        count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    done       = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        // ALU computes PC + (imm << 2) here so a CBZ target is ready in ALUOut
        alu_src_b = SRCB_IMM_SH2;
        case (cls_live)
          CLS_R:              state_nx = EXEC_R;
          CLS_LDUR, CLS_STUR: state_nx = ADDR;
          CLS_CBZ:            state_nx = CBZ_EX;
          default:            state_nx = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_nx  = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_nx  = FETCH;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nx  = (cls_q == CLS_LDUR) ? MEM_LD : MEM_ST;
      end
      MEM_LD: begin
        mem_read = 1'b1;
        if (bus.mem_ready)
          state_nx = WB_LD;
      end
      WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        state_nx   = FETCH;
      end
      MEM_ST: begin
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          done     = 1'b1;
          state_nx = FETCH;
        end
      end
      CBZ_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_PASSB;
        pc_src    = 1'b1;
        pc_write  = bus.Zero;
        done      = 1'b1;
        state_nx  = FETCH;
      end
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  assign reg2loc = (state != FETCH) && uses_rt_as_b(cls_cur);

  // Reset masks every output so nothing reaches the datapath mid-reset
  assign bus.PCWrite     = pc_write   & ~reset;
  assign bus.IRWrite     = ir_write   & ~reset;
  assign bus.MemRead     = mem_read   & ~reset;
  assign bus.MemWrite    = mem_write  & ~reset;
  assign bus.RegWrite    = reg_write  & ~reset;
  assign bus.MemtoReg    = mem_to_reg & ~reset;
  assign bus.Reg2Loc     = reg2loc    & ~reset;
  assign bus.ALUSrcA     = alu_src_a  & ~reset;
  assign bus.PCSrc       = pc_src     & ~reset;
  assign bus.ALUSrcB     = reset ? 2'b00 : alu_src_b;
  assign bus.ALUOp       = reset ? 2'b00 : alu_op;
  assign bus.instr_done  = done       & ~reset;
  assign bus.illegal     = illegal_q  & ~reset;
  assign bus.instr_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OPC_CBZ  = 11'b101_1010_0101;
  localparam logic [10:0] OPC_BAD  = 11'b000_0000_0000;

  typedef struct {
    logic [14:0]   v;
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [CW-1:0] ecnt = '0;
  exp_t sb[$];
  exp_t mon_e;
  logic [14:0] got;

  multicycle_ctrl_if #(.CNT_W(CW)) bus();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,MemtoReg,Reg2Loc,ALUSrcA,PCSrc,ALUSrcB,ALUOp,instr_done,illegal}
  function automatic logic [14:0] mk(input logic pcw, irw, mr, mw, rw, m2r, r2l, asa, pcs,
                                     input logic [1:0] asb, aop, input logic dn, il);
    return {pcw, irw, mr, mw, rw, m2r, r2l, asa, pcs, asb, aop, dn, il};
  endfunction

  localparam logic [14:0] V_ZERO  = 15'd0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      got = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg,
             bus.Reg2Loc, bus.ALUSrcA, bus.PCSrc, bus.ALUSrcB, bus.ALUOp, bus.instr_done,
             bus.illegal};
      total++;
      if (got !== mon_e.v) begin
        bad++;
        $display("FAIL %s ctrl got=%b want=%b", mon_e.nm, got, mon_e.v);
      end
      total++;
      if (bus.instr_count !== mon_e.cnt) begin
        bad++;
        $display("FAIL %s instr_count got=%0d want=%0d", mon_e.nm, bus.instr_count, mon_e.cnt);
      end
    end
  end

  task automatic step(input logic rst, input logic [10:0] op, input logic z, input logic rdy,
                      input logic [14:0] v, input string nm);
    exp_t e;
    reset         = rst;
    bus.Op        = op;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    e.v   = v;
    e.cnt = rst ? '0 : ecnt;
    e.nm  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rst) ecnt = '0;
    else if (v[1]) ecnt = ecnt + 1'b1;
  endtask

  task automatic fetch(input logic [10:0] op, input int waits);
    for (int i = 0; i < waits; i++)
      step(0, op, 0, 0, mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,0,0), "fetch_wait");
    step(0, op, 0, 1, mk(1,1,1,0,0,0,0,0,0,2'b01,2'b00,0,0), "fetch");
  endtask

  task automatic run_r(input int fwaits);
    fetch(OPC_ADD, fwaits);
    step(0, OPC_ADD, 1, 1, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), "r_decode");
    step(0, OPC_ADD, 1, 1, mk(0,0,0,0,0,0,0,1,0,2'b00,2'b10,0,0), "r_exec");
    step(0, OPC_ADD, 1, 1, mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,1,0), "r_wb");
  endtask

  task automatic run_ld(input int mwaits);
    fetch(OPC_LDUR, 0);
    step(0, OPC_LDUR, 0, 1, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), "ld_decode");
    step(0, OPC_LDUR, 0, 1, mk(0,0,0,0,0,0,0,1,0,2'b10,2'b00,0,0), "ld_addr");
    for (int i = 0; i < mwaits; i++)
      step(0, OPC_LDUR, 0, 0, mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,0,0), "ld_mem_wait");
    step(0, OPC_LDUR, 0, 1, mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,0,0), "ld_mem");
    step(0, OPC_LDUR, 0, 1, mk(0,0,0,0,1,1,0,0,0,2'b00,2'b00,1,0), "ld_wb");
  endtask

  task automatic st_head();
    fetch(OPC_STUR, 0);
    step(0, OPC_STUR, 0, 1, mk(0,0,0,0,0,0,1,0,0,2'b11,2'b00,0,0), "st_decode");
    step(0, OPC_STUR, 0, 1, mk(0,0,0,0,0,0,1,1,0,2'b10,2'b00,0,0), "st_addr");
  endtask

  task automatic run_cbz(input logic z);
    fetch(OPC_CBZ, 0);
    step(0, OPC_CBZ, z, 1, mk(0,0,0,0,0,0,1,0,0,2'b11,2'b00,0,0), "cbz_decode");
    step(0, OPC_CBZ, z, 1, mk(z,0,0,0,0,0,1,1,1,2'b00,2'b01,1,0), "cbz_ex");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.Op = '0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1, OPC_ADD, 0, 1, V_ZERO, "reset");
    step(1, OPC_ADD, 0, 1, V_ZERO, "reset");

    run_r(0);
    run_r(2);
    run_ld(2);
    st_head();
    step(0, OPC_STUR, 0, 1, mk(0,0,0,1,0,0,1,0,0,2'b00,2'b00,1,0), "st_mem");
    run_cbz(1);
    run_cbz(0);
    for (int i = 0; i < 10; i++) run_r(0);
    step(0, OPC_ADD, 0, 0, mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,0,0), "wrap_check");

    fetch(OPC_BAD, 0);
    step(0, OPC_BAD, 0, 1, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), "bad_decode");
    for (int i = 0; i < 12; i++)
      step(0, OPC_BAD, 0, 1, mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1), "trap");
    step(1, OPC_BAD, 0, 1, V_ZERO, "trap_reset");
    run_r(0);

    st_head();
    step(0, OPC_STUR, 0, 0, mk(0,0,0,1,0,0,1,0,0,2'b00,2'b00,0,0), "st_mem_wait");
    step(1, OPC_STUR, 0, 0, V_ZERO, "st_reset");
    run_r(1);

    if (sb.size() != 0) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multicycle LEGv8 datapath: sequences one instruction through fetch, decode, execute, memory and writeback using a single shared ALU and a single shared instruction/data memory. Handles the same instruction subset as the single-cycle main decoder (R-format, LDUR, STUR, CBZ). Stalls on a memory-ready handshake and traps on unsupported opcodes. Counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  11  opcode field IR[31:21]; valid from DECODE onward
- Zero  in  1  ALU zero flag, combinational from current ALU inputs
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, ALUSrcA, PCSrc  out  1 each  datapath controls
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  out  2  00 = add, 01 = pass B, 10 = funct-decoded
- instr_done  out  1  one-cycle pulse in the last cycle of each retired instruction
- illegal  out  1  sticky; set on an unsupported opcode
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W

## Operation
- Opcode classes, identical to the main decoder:
  - LDUR = 111_1100_0010
  - STUR = 111_1100_0000
  - CBZ = 101_1010_0???
  - R = 1??_0101_?000
  - anything else = ILL
- Class is sampled in DECODE and registered for later states.
- Outputs not listed for a state are 0.
- States, outputs and next state:
  - FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE. Otherwise stay in FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; the branch target is latched into ALUOut. Next state by class: R→EXEC_R, LDUR/STUR→ADDR, CBZ→CBZ_EX, ILL→TRAP.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_R.
  - WB_R: RegWrite=1, MemtoReg=0, instr_done=1 → FETCH.
  - ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_LD (LDUR) or MEM_ST (STUR).
  - MEM_LD: MemRead=1; when mem_ready=1 → WB_LD, otherwise stay.
  - WB_LD: RegWrite=1, MemtoReg=1, instr_done=1 → FETCH.
  - MEM_ST: MemWrite=1; when mem_ready=1, instr_done=1 → FETCH, otherwise stay.
  - CBZ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero, instr_done=1 → FETCH.
  - TRAP: all controls 0, illegal=1; stays in TRAP until reset.
- Reg2Loc = 1 in every state except FETCH when the registered class (or, in DECODE, the live class) is STUR or CBZ.
- instr_count increments by 1 in any cycle where instr_done=1. CBZ counts whether or not the branch is taken.

## Timing
- Reset values: state=FETCH, class=R, instr_count=0, illegal=0.
- While reset=1, all outputs are forced to 0 (including the FETCH MemRead). The first active fetch occurs in the first cycle after reset deasserts.
- Reset mid-instruction, including during a MEM_ST wait: MemWrite drops in the reset cycle. No partial writeback.
- Cycles per instruction with zero-wait memory: R=4, LDUR=5, STUR=4, CBZ=3. Each cycle with mem_ready=0 in FETCH, MEM_LD or MEM_ST adds 1 cycle.
- Control outputs are combinational from the registered state and class, plus Zero and mem_ready; there are no glitch constraints beyond a single clock.
- instr_done and the counter increment occur in the same cycle; the new count is visible on the next cycle.
- instr_count wraps from all-ones to 0 with no flag.

## Structure
- Shared package leg_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_LD, WB_LD, MEM_ST, CBZ_EX, TRAP)
  - class enum (R, LDUR, STUR, CBZ, ILL)
  - opcode casez patterns
  - ALUOp and ALUSrcB encodings
- Sub-module op_class: combinational Op → class. It is reused by the main decoder for consistency.
- The FSM state register, class register, sticky illegal flag and counter live in multicycle_ctrl.

## Test plan
- R-format ADD, Op=100_0101_1000, mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_R. RegWrite=1 only in cycle 4; instr_count 0→1.
- LDUR, Op=111_1100_0010, mem_ready low for 2 cycles in MEM_LD → 7 cycles total. MemtoReg=1 with RegWrite in the final cycle.
- STUR, Op=111_1100_0000 → Reg2Loc=1 from DECODE through MEM_ST. MemWrite=1 for exactly one cycle with mem_ready=1; RegWrite never asserts.
- CBZ, Op=101_1010_0101 → in CBZ_EX: with Zero=1, PCWrite=1 and PCSrc=1; with Zero=0, PCWrite=0. Both cases take 3 cycles and both count as retired.
- Op=000_0000_0000 → TRAP after DECODE; illegal=1 and held for 10+ cycles. A reset pulse clears illegal and restarts at FETCH.
- Counter wrap with CNT_W=4: retire 16 R-format instructions → instr_count reads 0. Asserting reset in the MEM_ST wait → MemWrite=0 that cycle, instr_count=0.
